// File: rtl/python_sync_pkg.sv
// Shared sync-code constants, parser states and error-flag indices for the
// PYTHON sync-word parser family.
package python_sync_pkg;

    localparam logic [9:0] SYNC_TR    = 10'h3a6;
    localparam logic [9:0] SYNC_BS    = 10'h22a;
    localparam logic [9:0] SYNC_BL    = 10'h015;
    localparam logic [9:0] SYNC_BE_LE = 10'h12a;
    localparam logic [9:0] SYNC_FS    = 10'h2aa;
    localparam logic [9:0] SYNC_FE    = 10'h3aa;
    localparam logic [9:0] SYNC_LS    = 10'h0aa;
    localparam logic [9:0] SYNC_PX    = 10'h035;
    localparam logic [9:0] SYNC_CRC   = 10'h059;

    typedef enum logic [1:0] {
        IDLE,
        BLACK,
        FRAME,
        LINE
    } state_t;

    localparam int unsigned ERR_BITS        = 4;
    localparam int unsigned ERR_UNKNOWN     = 0;
    localparam int unsigned ERR_PX_OUTSIDE  = 1;
    localparam int unsigned ERR_LINE_LEN    = 2;
    localparam int unsigned ERR_FS_IN_FRAME = 3;

endpackage

// File: rtl/python_sync_parser_ex_decode.sv
// Combinational one-hot classification of a sync word.
module python_sync_decode
    import python_sync_pkg::*;
#(
    parameter int unsigned DATA_BITS = 10
) (
    input  logic [DATA_BITS-1:0] sync,
    output logic                 is_bs,
    output logic                 is_bl,
    output logic                 is_12a,
    output logic                 is_fs,
    output logic                 is_fe,
    output logic                 is_ls,
    output logic                 is_px,
    output logic                 is_ign,
    output logic                 is_unknown
);

    function automatic logic match(input logic [DATA_BITS-1:0] s, input logic [9:0] code);
        return s == DATA_BITS'(code);
    endfunction

    // Compare against every known code; anything else is flagged unknown.
    always_comb begin
        is_bs      = match(sync, SYNC_BS);
        is_bl      = match(sync, SYNC_BL);
        is_12a     = match(sync, SYNC_BE_LE);
        is_fs      = match(sync, SYNC_FS);
        is_fe      = match(sync, SYNC_FE);
        is_ls      = match(sync, SYNC_LS);
        is_px      = match(sync, SYNC_PX);
        is_ign     = match(sync, SYNC_TR) | match(sync, SYNC_CRC);
        is_unknown = ~(is_bs | is_bl | is_12a | is_fs | is_fe | is_ls | is_px | is_ign);
    end

endmodule

// File: rtl/python_sync_parser_ex.sv
// Sync-word parser: line/frame state machine, beat generation into an
// AXI4-Stream master (two-stage pipeline), geometry stats and sticky errors.
module python_sync_parser_ex
    import python_sync_pkg::*;
#(
    parameter int unsigned LANES     = 4,
    parameter int unsigned DATA_BITS = 10,
    parameter int unsigned H_BITS    = 12,
    parameter int unsigned V_BITS    = 12,
    parameter int unsigned FC_BITS   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cke,
    input  logic                         csi_mode,
    input  logic                         black_enable,
    input  logic                         err_clear,
    input  logic [LANES*DATA_BITS-1:0]   s_data,
    input  logic [DATA_BITS-1:0]         s_sync,
    input  logic                         s_valid,
    output logic                         frame_start,
    output logic [LANES*DATA_BITS-1:0]   m_tdata,
    output logic [1:0]                   m_tuser,
    output logic                         m_tlast,
    output logic                         m_tvalid,
    output logic [H_BITS-1:0]            stat_width,
    output logic [V_BITS-1:0]            stat_height,
    output logic [FC_BITS-1:0]           stat_frames,
    output logic [ERR_BITS-1:0]          err_flags
);

    logic is_bs, is_bl, is_12a, is_fs, is_fe, is_ls, is_px, is_ign, is_unknown;

    python_sync_decode #(.DATA_BITS(DATA_BITS)) u_decode (
        .sync       (s_sync),
        .is_bs      (is_bs),
        .is_bl      (is_bl),
        .is_12a     (is_12a),
        .is_fs      (is_fs),
        .is_fe      (is_fe),
        .is_ls      (is_ls),
        .is_px      (is_px),
        .is_ign     (is_ign),
        .is_unknown (is_unknown)
    );

    state_t state, state_nxt;
    logic csi_lat, blk_lat, sof_done;
    logic eff_csi, eff_blk, fwd_blk;
    logic [H_BITS-1:0] h_cnt, line_len, first_len;
    logic [V_BITS-1:0] v_cnt, v_next;
    logic first_done;

    logic beat, beat_sof, beat_blk, beat_last;
    logic frame_open, line_open, line_word, line_end, frame_end;
    logic [ERR_BITS-1:0] err_set;

    logic                       d_valid, d_last;
    logic [1:0]                 d_user;
    logic [LANES*DATA_BITS-1:0] d_data;

    // Mode is live while idle and frozen for the rest of the frame; saturating increments.
    always_comb begin
        eff_csi  = (state == IDLE) ? csi_mode     : csi_lat;
        eff_blk  = (state == IDLE) ? black_enable : blk_lat;
        fwd_blk  = ~eff_csi & eff_blk;
        line_len = (h_cnt == '1) ? h_cnt : h_cnt + H_BITS'(1);
        v_next   = (v_cnt == '1) ? v_cnt : v_cnt + V_BITS'(1);
    end

    // Next state, beat decision, counter strobes and error set pulses.
    always_comb begin
        state_nxt  = state;
        beat       = 1'b0;
        beat_sof   = 1'b0;
        beat_blk   = 1'b0;
        beat_last  = 1'b0;
        frame_open = 1'b0;
        line_open  = 1'b0;
        line_word  = 1'b0;
        line_end   = 1'b0;
        frame_end  = 1'b0;
        err_set    = '0;
        if (s_valid) begin
            if (is_unknown) begin
                err_set[ERR_UNKNOWN] = 1'b1;
            end else if (!is_ign) begin
                if (is_fs) begin
                    // FS restarts the frame from any state; only FRAME/LINE flag it.
                    state_nxt  = LINE;
                    frame_open = 1'b1;
                    line_open  = 1'b1;
                    beat       = 1'b1;
                    beat_sof   = ~sof_done;
                    if (state == FRAME || state == LINE)
                        err_set[ERR_FS_IN_FRAME] = 1'b1;
                end else if (is_px && state != LINE) begin
                    err_set[ERR_PX_OUTSIDE] = 1'b1;
                end else begin
                    case (state)
                        IDLE: begin
                            if (is_bs) begin
                                state_nxt = BLACK;
                                beat      = fwd_blk;
                                beat_blk  = fwd_blk;
                                beat_sof  = fwd_blk;
                            end
                        end
                        BLACK: begin
                            if (is_bl) begin
                                beat     = fwd_blk;
                                beat_blk = fwd_blk;
                            end else if (is_12a) begin
                                state_nxt = IDLE;
                                beat      = fwd_blk;
                                beat_blk  = fwd_blk;
                            end
                        end
                        FRAME: begin
                            if (is_ls) begin
                                state_nxt = LINE;
                                line_open = 1'b1;
                                beat      = 1'b1;
                            end else if (is_fe) begin
                                state_nxt = IDLE;
                                frame_end = 1'b1;
                            end
                        end
                        LINE: begin
                            if (is_px) begin
                                line_word = 1'b1;
                                beat      = 1'b1;
                            end else if (is_12a) begin
                                state_nxt = FRAME;
                                line_end  = 1'b1;
                                beat      = 1'b1;
                                beat_last = eff_csi;
                            end else if (is_fe) begin
                                state_nxt = IDLE;
                                line_end  = 1'b1;
                                frame_end = 1'b1;
                                beat      = 1'b1;
                                beat_last = 1'b1;
                            end
                        end
                        default: state_nxt = IDLE;
                    endcase
                end
            end
        end
        if (line_end && first_done && line_len != first_len)
            err_set[ERR_LINE_LEN] = 1'b1;
    end

    // State register, frame-scoped mode latch and start-of-frame bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            csi_lat  <= 1'b0;
            blk_lat  <= 1'b0;
            sof_done <= 1'b0;
        end else if (cke) begin
            state <= state_nxt;
            if (state == IDLE) begin
                csi_lat <= csi_mode;
                blk_lat <= black_enable;
            end
            if (frame_open)
                sof_done <= 1'b0;
            else if (beat && beat_blk && beat_sof)
                sof_done <= 1'b1;
        end
    end

    // Decode register followed by output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_valid     <= 1'b0;
            d_data      <= '0;
            d_user      <= '0;
            d_last      <= 1'b0;
            m_tvalid    <= 1'b0;
            m_tdata     <= '0;
            m_tuser     <= '0;
            m_tlast     <= 1'b0;
            frame_start <= 1'b0;
        end else if (cke) begin
            d_valid     <= beat;
            d_user      <= {beat_blk, beat_sof};
            d_last      <= beat_last;
            if (beat)
                d_data <= s_data;
            m_tvalid    <= d_valid;
            m_tuser     <= d_user;
            m_tlast     <= d_last;
            if (d_valid)
                m_tdata <= d_data;
            frame_start <= frame_open;
        end
    end

    // Line/frame geometry counters and published statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            first_len   <= '0;
            first_done  <= 1'b0;
            stat_width  <= '0;
            stat_height <= '0;
            stat_frames <= '0;
        end else if (cke) begin
            if (line_open)
                h_cnt <= H_BITS'(1);
            else if (line_word)
                h_cnt <= line_len;
            if (frame_open) begin
                v_cnt      <= '0;
                first_done <= 1'b0;
            end
            if (line_end) begin
                stat_width <= line_len;
                v_cnt      <= v_next;
                if (!first_done) begin
                    first_len  <= line_len;
                    first_done <= 1'b1;
                end
            end
            if (frame_end) begin
                stat_height <= line_end ? v_next : v_cnt;
                stat_frames <= stat_frames + FC_BITS'(1);
            end
        end
    end

    // Sticky error flags; a new set wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset)
            err_flags <= '0;
        else if (cke)
            err_flags <= (err_flags & ~{ERR_BITS{err_clear}}) | err_set;
    end

endmodule

// File: tb/tb_python_sync_parser_ex.sv
// Scoreboard bench for python_sync_parser_ex: each driven word pushes its
// expected beat; the monitor pops and compares beats and their latency.
module tb_python_sync_parser_ex;

    localparam int unsigned LANES = 4, DATA_BITS = 10, H_BITS = 12, V_BITS = 12, FC_BITS = 16;
    localparam int unsigned W = LANES * DATA_BITS;

    localparam logic [9:0] TR = 10'h3a6, BS = 10'h22a, BL = 10'h015, BE = 10'h12a, LE = 10'h12a;
    localparam logic [9:0] FS = 10'h2aa, FE = 10'h3aa, LS = 10'h0aa, PX = 10'h035, CRC = 10'h059;

    localparam int unsigned NPX = 166, NBL = 320, NLINES = 48;

    logic clk = 1'b0, reset = 1'b1, cke = 1'b1, csi_mode = 1'b0, black_enable = 1'b0, err_clear = 1'b0;
    logic [W-1:0] s_data = '0;
    logic [DATA_BITS-1:0] s_sync = '0;
    logic s_valid = 1'b0;
    logic frame_start, m_tlast, m_tvalid;
    logic [W-1:0] m_tdata;
    logic [1:0] m_tuser;
    logic [H_BITS-1:0] stat_width;
    logic [V_BITS-1:0] stat_height;
    logic [FC_BITS-1:0] stat_frames;
    logic [3:0] err_flags;

    python_sync_parser_ex #(
        .LANES(LANES), .DATA_BITS(DATA_BITS), .H_BITS(H_BITS), .V_BITS(V_BITS), .FC_BITS(FC_BITS)
    ) dut (
        .clk(clk), .reset(reset), .cke(cke), .csi_mode(csi_mode), .black_enable(black_enable),
        .err_clear(err_clear), .s_data(s_data), .s_sync(s_sync), .s_valid(s_valid),
        .frame_start(frame_start), .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .stat_width(stat_width), .stat_height(stat_height),
        .stat_frames(stat_frames), .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   user;
        logic         last;
        int           issue;
    } beat_t;

    beat_t sb[$];
    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    int exp_fs_cyc = -10;
    int blk_beats = 0, img_beats = 0, last_beats = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] sync, input bit beat, input logic [1:0] user, input bit last);
        beat_t e;
        s_sync  = sync;
        s_data  = {8'($urandom), 32'($urandom)};
        s_valid = 1'b1;
        if (sync == FS) exp_fs_cyc = cyc;
        if (beat) begin
            e.data  = s_data;
            e.user  = user;
            e.last  = last;
            e.issue = cyc;
            sb.push_back(e);
        end
        step();
    endtask

    task automatic idle(input int unsigned n);
        s_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_line(input logic [9:0] open, input int unsigned npx, input logic [9:0] close,
                             input logic [1:0] open_user, input bit close_last);
        send(open, 1'b1, open_user, 1'b0);
        repeat (npx) send(PX, 1'b1, 2'b00, 1'b0);
        send(close, 1'b1, 2'b00, close_last);
    endtask

    task automatic clear_errors();
        s_valid   = 1'b0;
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        step();
    endtask

    task automatic do_reset(input int unsigned n);
        reset   = 1'b1;
        s_valid = 1'b0;
        step();
        sb.delete();
        check_eq("rst_tvalid", 64'(m_tvalid), 64'd0);
        check_eq("rst_tuser_tlast", 64'({m_tuser, m_tlast}), 64'd0);
        check_eq("rst_tdata", 64'(m_tdata), 64'd0);
        check_eq("rst_frame_start", 64'(frame_start), 64'd0);
        check_eq("rst_stats", 64'({stat_width, stat_height, stat_frames}), 64'd0);
        check_eq("rst_err", 64'(err_flags), 64'd0);
        repeat (n - 1) step();
        reset = 1'b0;
    endtask

    task automatic monitor();
        beat_t e;
        bit exp_fs;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_fs = (cyc == exp_fs_cyc + 1);
                if (frame_start || exp_fs)
                    check_eq("frame_start", 64'(frame_start), 64'(exp_fs));
                if (m_tvalid) begin
                    if (m_tuser[1]) blk_beats++; else img_beats++;
                    if (m_tlast) last_beats++;
                    if (sb.size() == 0) begin
                        check_eq("spurious_beat", 64'(m_tvalid), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("beat", 64'({m_tdata, m_tuser, m_tlast}), 64'({e.data, e.user, e.last}));
                        check_eq("latency", 64'(cyc - e.issue), 64'd2);
                    end
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, i0, l0;
        fork
            monitor();
        join_none

        do_reset(3);

        // Raw mode, black forwarded; TR and CRC words must be ignored.
        csi_mode = 1'b0; black_enable = 1'b1;
        b0 = blk_beats; i0 = img_beats; l0 = last_beats;
        send(BS, 1'b1, 2'b11, 1'b0);
        repeat (NBL / 2) send(BL, 1'b1, 2'b10, 1'b0);
        send(TR, 1'b0, 2'b00, 1'b0);
        repeat (NBL / 2) send(BL, 1'b1, 2'b10, 1'b0);
        send(BE, 1'b1, 2'b10, 1'b0);
        send(FS, 1'b1, 2'b00, 1'b0);
        repeat (10) send(PX, 1'b1, 2'b00, 1'b0);
        send(CRC, 1'b0, 2'b00, 1'b0);
        repeat (NPX - 10) send(PX, 1'b1, 2'b00, 1'b0);
        send(LE, 1'b1, 2'b00, 1'b0);
        for (int unsigned i = 0; i < NLINES - 2; i++) send_line(LS, NPX, LE, 2'b00, 1'b0);
        send_line(LS, NPX, FE, 2'b00, 1'b1);
        idle(4);
        check_eq("raw_black_beats", 64'(blk_beats - b0), 64'(NBL + 2));
        check_eq("raw_image_beats", 64'(img_beats - i0), 64'(NLINES * (NPX + 2)));
        check_eq("raw_tlast_count", 64'(last_beats - l0), 64'd1);
        check_eq("raw_width", 64'(stat_width), 64'(NPX + 2));
        check_eq("raw_height", 64'(stat_height), 64'(NLINES));
        check_eq("raw_frames", 64'(stat_frames), 64'd1);
        check_eq("raw_err", 64'(err_flags), 64'd0);

        // CSI mode; mode inputs flipped mid-frame must not take effect.
        csi_mode = 1'b1; black_enable = 1'b1;
        b0 = blk_beats; i0 = img_beats; l0 = last_beats;
        send(BS, 1'b0, 2'b00, 1'b0);
        repeat (NBL) send(BL, 1'b0, 2'b00, 1'b0);
        send(BE, 1'b0, 2'b00, 1'b0);
        send_line(FS, NPX, LE, 2'b01, 1'b1);
        csi_mode = 1'b0; black_enable = 1'b0;
        for (int unsigned i = 0; i < NLINES - 2; i++) send_line(LS, NPX, LE, 2'b00, 1'b1);
        send_line(LS, NPX, FE, 2'b00, 1'b1);
        idle(4);
        check_eq("csi_black_beats", 64'(blk_beats - b0), 64'd0);
        check_eq("csi_image_beats", 64'(img_beats - i0), 64'(NLINES * (NPX + 2)));
        check_eq("csi_tlast_count", 64'(last_beats - l0), 64'(NLINES));
        check_eq("csi_frames", 64'(stat_frames), 64'd2);

        // Stray PX between lines, then a long fifth line.
        csi_mode = 1'b0; black_enable = 1'b0;
        send_line(FS, NPX, LE, 2'b01, 1'b0);
        send(PX, 1'b0, 2'b00, 1'b0);
        idle(3);
        check_eq("err_px_outside", 64'(err_flags), 64'b0010);
        clear_errors();
        check_eq("err_cleared", 64'(err_flags), 64'd0);
        for (int unsigned i = 0; i < 3; i++) send_line(LS, NPX, LE, 2'b00, 1'b0);
        send_line(LS, NPX + 2, LE, 2'b00, 1'b0);
        idle(3);
        check_eq("err_line_len", 64'(err_flags), 64'b0100);
        check_eq("long_width", 64'(stat_width), 64'(NPX + 4));
        send_line(LS, NPX, FE, 2'b00, 1'b1);
        idle(4);
        check_eq("len_height", 64'(stat_height), 64'd6);
        check_eq("len_frames", 64'(stat_frames), 64'd3);
        check_eq("len_err_keep", 64'(err_flags), 64'b0100);

        // Set wins over a simultaneous clear.
        err_clear = 1'b1;
        send(PX, 1'b0, 2'b00, 1'b0);
        err_clear = 1'b0;
        idle(3);
        check_eq("err_set_priority", 64'(err_flags), 64'b0010);
        clear_errors();

        // Unknown sync word, then FS inside a line restarts the frame.
        send(10'h3ff, 1'b0, 2'b00, 1'b0);
        idle(3);
        check_eq("err_unknown", 64'(err_flags), 64'b0001);
        clear_errors();
        send_line(FS, NPX, LE, 2'b01, 1'b0);
        send(LS, 1'b1, 2'b00, 1'b0);
        repeat (20) send(PX, 1'b1, 2'b00, 1'b0);
        send(FS, 1'b1, 2'b01, 1'b0);
        idle(3);
        check_eq("err_fs_in_frame", 64'(err_flags), 64'b1000);
        check_eq("abort_frames", 64'(stat_frames), 64'd3);
        repeat (NPX) send(PX, 1'b1, 2'b00, 1'b0);
        send(LE, 1'b1, 2'b00, 1'b0);
        send_line(LS, NPX, FE, 2'b00, 1'b1);
        idle(4);
        check_eq("restart_frames", 64'(stat_frames), 64'd4);
        check_eq("restart_height", 64'(stat_height), 64'd2);
        check_eq("restart_err", 64'(err_flags), 64'b1000);
        clear_errors();

        // Reset in the middle of a line; out-of-context words before FS are dropped.
        send_line(FS, NPX, LE, 2'b01, 1'b0);
        send(LS, 1'b1, 2'b00, 1'b0);
        repeat (50) send(PX, 1'b1, 2'b00, 1'b0);
        do_reset(3);
        idle(2);
        send(LS, 1'b0, 2'b00, 1'b0);
        send(LE, 1'b0, 2'b00, 1'b0);
        send(FE, 1'b0, 2'b00, 1'b0);
        idle(3);
        check_eq("post_reset_frames", 64'(stat_frames), 64'd0);
        send_line(FS, NPX, LE, 2'b01, 1'b0);
        send_line(LS, NPX, FE, 2'b00, 1'b1);
        idle(4);
        check_eq("post_reset_width", 64'(stat_width), 64'(NPX + 2));
        check_eq("post_reset_height", 64'(stat_height), 64'd2);
        check_eq("post_reset_frames2", 64'(stat_frames), 64'd1);
        check_eq("post_reset_err", 64'(err_flags), 64'd0);

        check_eq("sb_drain", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/python_sync_parser_ex.md
Name: python_sync_parser_ex

Overview:
- Parametrised successor of the PYTHON300 sync-word parser: decodes the per-word sync channel of the N-lane deserialised sensor stream and emits an AXI4-Stream master (tready not supported; sink always ready).
- Adds over the previous generation: parametrised lane count and bit width; an explicit line/frame state machine that disambiguates the shared 0x12a code (black end vs line end); dropping of out-of-context words; per-frame geometry measurement; sticky protocol-error flags.
- Sits between the lane-alignment block and the CSI-2 packer / video DMA.

Parameters:
- LANES, 4, pixel lanes per word.
- DATA_BITS, 10, bits per lane and width of the sync word.
- H_BITS, 12, width of the word-per-line counter.
- V_BITS, 12, width of the line-per-frame counter.
- FC_BITS, 16, width of the frame counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cke  in  1  clock enable; when low all state holds.
- csi_mode  in  1  1: image lines only, tlast per line; 0: black + image, tlast per frame.
- black_enable  in  1  in raw mode (csi_mode=0), forward black words.
- err_clear  in  1  clears sticky error flags.
- s_data  in  LANES*DATA_BITS  lane data.
- s_sync  in  DATA_BITS  sync word.
- s_valid  in  1  word valid.
- frame_start  out  1  one-cycle pulse on the frame-start sync.
- m_tdata  out  LANES*DATA_BITS  output data.
- m_tuser  out  2  [0] start of frame, [1] black word.
- m_tlast  out  1  end of line (csi) or end of frame (raw).
- m_tvalid  out  1  beat valid.
- stat_width  out  H_BITS  words in the last completed image line.
- stat_height  out  V_BITS  image lines in the last completed frame.
- stat_frames  out  FC_BITS  completed-frame count; wraps.
- err_flags  out  4  sticky error flags: [0] unknown sync, [1] pixel outside line, [2] line-length mismatch, [3] frame start inside frame.

Behaviour:
- Sync codes (10-bit): TR 3a6, BS 22a, BL 015, BE/LE 12a, FS 2aa, FE 3aa, LS 0aa, PX 035, CRC 059.
  - Only words with s_valid=1 and cke=1 are decoded.
- States: IDLE, BLACK, FRAME, LINE.
  - IDLE: BS -> BLACK; FS -> LINE (the frame-start word opens the first line).
  - BLACK: BL stays; 12a (= BE) -> IDLE; FS -> LINE.
  - FRAME: LS -> LINE; FE -> IDLE.
  - LINE: PX stays; 12a (= LE) -> FRAME; FE -> IDLE.
- Counting rules:
  - FE closes both the line and the frame.
  - FS and LS count as the first word of a line.
  - PX, LE and FE count as line words.
  - TR and CRC are ignored in all states.
- Beat generation:
  - Image beat: any word counted in LINE.
  - Black beat: BS, BL or BE while in BLACK, only when csi_mode=0 and black_enable=1.
  - All other words produce no beat.
- Beat attributes:
  - m_tuser[0]=1 on the first beat of the frame: the FS beat, or the BS beat when black beats are forwarded.
  - m_tuser[1]=1 on black beats.
  - m_tlast: csi_mode=1 on LE/FE beats; csi_mode=0 on the FE beat only.
- Latency: exactly 2 cycles from the s_valid word to m_tvalid (decode register, then output register). Output registers update only when cke=1.
- frame_start: asserted one cycle after an FS word (1-cycle latency), for one cycle.
- Width counter h_cnt:
  - Loads 1 on FS/LS, increments on each counted line word.
  - At LE/FE, stat_width <= h_cnt+1.
  - Saturates at all-ones.
- Height counter v_cnt:
  - Reset on FS, increments at each line end.
  - At FE, stat_height <= v_cnt+1 and stat_frames increments (modulo 2^FC_BITS).
- err[0]: s_sync matches no listed code.
- err[1]: PX while not in LINE. The word is dropped.
- err[2]: second or later line of a frame whose length differs from the first line of that frame.
- err[3]: FS while in FRAME or LINE. The frame restarts: the state machine behaves as on FS from IDLE, and stat_height / stat_frames are not updated for the aborted frame.
- Error flags are sticky; err_clear clears them. Set has priority over clear in the same cycle.
- csi_mode and black_enable are sampled only in IDLE, so a frame is never split across modes.
- Reset (including mid-frame):
  - State -> IDLE; m_tvalid, m_tlast, m_tuser, frame_start = 0.
  - All stat_* = 0; err_flags = 0.
  - m_tdata = 0.
  - The first output after reset is the next FS/BS.

Decomposition:
- Package python_sync_pkg holds:
  - sync-code localparams (SYNC_TR … SYNC_CRC);
  - state enum typedef (IDLE/BLACK/FRAME/LINE);
  - error-bit index constants.
- One sub-module, python_sync_decode: combinational classification of s_sync into one-hot {is_bs, is_bl, is_12a, is_fs, is_fe, is_ls, is_px, is_ign, is_unknown}. Shared with future lane-count variants.

Test Plan:
- Raw, black on: BS, 320×BL, BE, FS, 166×PX, LE, then LS/166 PX/LE ×478, then LS, 166 PX, FE. Required:
  - 322 black beats (first with tuser=11, rest tuser[1]=1).
  - 480×168 image beats.
  - One tlast, on the FE beat.
  - stat_width=168, stat_height=480, stat_frames=1.
- Same stimulus, csi_mode=1: no black beats; tuser[0] on the FS beat; 480 tlast pulses; each beat 2 cycles after its input word.
- PX injected between LE and LS -> word dropped, err_flags=0010; err_clear pulse -> 0000.
- Line 5 has 170 words -> err_flags[2]=1; stat_width=170 after line 5.
- Sync word 0x3ff -> err[0]=1; FS mid-line -> err[3]=1, new frame starts, stat_frames unchanged.
- Reset asserted mid-line for 3 cycles -> m_tvalid=0 next cycle, stats zero, no beats until the next FS.
